inst_loader: RTL

- Boot-time program loader that drives the CPU's debug instruction-RAM write port: `debug`, `inst_ram_write_enable`, `inst_ram_write_data` and `inst_ram_write_address`.
- It accepts a framed byte stream on a valid/ready interface and assembles the bytes into little-endian 32-bit words.
- It writes those words to consecutive instruction-RAM addresses, holding the CPU in reset for the whole load.
- After a successful load it drops `debug`, then releases the CPU.

---
 rtl/inst_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// inst_loader: boot-time loader that streams a framed byte stream into CPU instruction RAM
module inst_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        debug,
    output logic        inst_ram_write_enable,
    output logic [31:0] inst_ram_write_data,
    output logic [31:0] inst_ram_write_address,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, WR, RELEASE, ERR} state_t;

    state_t      state, state_next;
    logic [1:0]  byte_cnt;
    logic [31:0] shift_reg, word_count, word_idx, assembled;
    logic        accept, last_byte, bad_count, last_word, launch;

    // the header and payload share one shift register: the count is latched before data arrives
    assign assembled = {rx_data, shift_reg[31:8]};
    assign rx_ready  = state == HDR || state == DATA;
    assign busy      = state == HDR || state == DATA || state == WR || state == RELEASE;
    assign accept    = rx_valid && rx_ready;
    assign last_byte = accept && byte_cnt == 2'd3;
    assign bad_count = assembled == 32'd0 || assembled > MAX_WORDS;
    assign last_word = word_idx + 32'd1 == word_count;
    assign launch    = start && (state == IDLE || state == ERR);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // next-state decode: byte-driven states only advance on a completed 4-byte group
    always_comb begin
        state_next = state;
        case (state)
            IDLE, ERR: state_next = start ? HDR : state;
            HDR:       state_next = last_byte ? (bad_count ? ERR : DATA) : HDR;
            DATA:      state_next = last_byte ? WR : DATA;
            WR:        state_next = last_word ? RELEASE : DATA;
            RELEASE:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // byte assembly and frame bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt   <= 2'd0;
            shift_reg  <= 32'd0;
            word_count <= 32'd0;
            word_idx   <= 32'd0;
        end else begin
            if (launch) byte_cnt <= 2'd0;
            if (accept) begin
                byte_cnt  <= byte_cnt + 2'd1;
                shift_reg <= assembled;
            end
            if (state == HDR && last_byte) begin
                word_count <= assembled;
                word_idx   <= 32'd0;
            end
            if (state == WR) word_idx <= word_idx + 32'd1;
        end
    end

    // registered write port: address and data are captured with the strobe so they are stable in WR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_ram_write_enable  <= 1'b0;
            inst_ram_write_data    <= 32'd0;
            inst_ram_write_address <= 32'd0;
        end else begin
            inst_ram_write_enable <= state == DATA && last_byte;
            if (state == DATA && last_byte) begin
                inst_ram_write_data    <= assembled;
                inst_ram_write_address <= BASE_ADDR + word_idx * ADDR_STEP;
            end
        end
    end

    // CPU control and status: debug drops one cycle before the CPU leaves reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            debug     <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (launch) begin
                debug     <= 1'b1;
                cpu_reset <= 1'b1;
                done      <= 1'b0;
                error     <= 1'b0;
            end
            if (state == HDR && last_byte && bad_count) begin
                debug <= 1'b0;
                error <= 1'b1;
            end
            if (state == WR && last_word) debug <= 1'b0;
            if (state == RELEASE) begin
                cpu_reset <= 1'b0;
                done      <= 1'b1;
            end
        end
    end
endmodule
